// File: rtl/ssd_capture.sv
// ssd_capture: receive side of the multiplexed 7-segment bus. Waits for each
// digit's pattern to settle, decodes it back to a nibble, assembles a full
// multi-digit word and offers it on a valid/ready output.
module ssd_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   word_out,
  output logic [DIGITS-1:0]     bad_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {SYNC, COLLECT} state_t;

  // Active-low one-hot: exactly one anode pulled low.
  function automatic logic onehot_low(input logic [DIGITS-1:0] an);
    logic [DIGITS-1:0] x;
    x = ~an;
    return (x != '0) && ((x & (x - DIGITS'(1))) == '0);
  endfunction

  // Returns {bad, nibble}; unknown patterns (blank included) give nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: return 5'h00;  7'h79: return 5'h01;
      7'h24: return 5'h02;  7'h30: return 5'h03;
      7'h19: return 5'h04;  7'h12: return 5'h05;
      7'h02: return 5'h06;  7'h78: return 5'h07;
      7'h00: return 5'h08;  7'h10: return 5'h09;
      7'h08: return 5'h0A;  7'h03: return 5'h0B;
      7'h46: return 5'h0C;  7'h21: return 5'h0D;
      7'h06: return 5'h0E;  7'h0E: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  logic [DIGITS-1:0] samp_an;
  logic [6:0]        samp_seg;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              same, capture;
  logic [IW-1:0]     pin_idx;

  // The counter is evaluated against the value about to enter samp, so the
  // capture lands on the same edge that the counter reaches STABLE_CYC.
  assign same = ({an_in, seg_in} == {samp_an, samp_seg});

  // Stability run length, saturating so a held digit captures only once.
  always_comb begin
    cnt_nxt = CW'(1);
    if (same) cnt_nxt = (cnt == CW'(STABLE_CYC)) ? cnt : cnt + CW'(1);
  end

  assign capture = (cnt_nxt == CW'(STABLE_CYC)) && (cnt != CW'(STABLE_CYC)) &&
                   onehot_low(an_in);

  // Position of the low anode (only meaningful when one-hot).
  always_comb begin
    pin_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!an_in[i]) pin_idx = IW'(i);
  end

  // Input sample register and stability counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_an  <= '1;
      samp_seg <= 7'h7F;
      cnt      <= '0;
    end else begin
      samp_an  <= an_in;
      samp_seg <= seg_in;
      cnt      <= cnt_nxt;
    end
  end

  logic          cap_vld;
  logic [IW-1:0] cap_idx;
  logic [6:0]    cap_seg;

  // Capture event register: which digit settled and on what pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_vld <= 1'b0;
      cap_idx <= '0;
      cap_seg <= 7'h7F;
    end else begin
      cap_vld <= capture;
      cap_idx <= pin_idx;
      cap_seg <= samp_seg_nxt();
    end
  end

  function automatic logic [6:0] samp_seg_nxt();
    return seg_in;
  endfunction

  state_t              state;
  logic [4*DIGITS-1:0] shadow_word, shadow_word_nxt;
  logic [DIGITS-1:0]   shadow_bad, shadow_bad_nxt;
  logic [DIGITS-1:0]   seen, seen_nxt;
  logic                cap_bad, complete, take;
  logic [3:0]          cap_nib;

  // Shadow update and frame-completion detect; SYNC only accepts digit 0.
  always_comb begin
    {cap_bad, cap_nib} = decode(cap_seg);
    shadow_word_nxt = shadow_word;
    shadow_bad_nxt  = shadow_bad;
    seen_nxt        = seen;
    complete        = 1'b0;
    take            = cap_vld && ((state == COLLECT) || (cap_idx == '0));
    if (take) begin
      shadow_word_nxt[cap_idx*4 +: 4] = cap_nib;
      shadow_bad_nxt[cap_idx]         = cap_bad;
      seen_nxt = (state == SYNC) ? DIGITS'(1) : (seen | (DIGITS'(1) << cap_idx));
      if (&seen_nxt) begin
        complete = 1'b1;
        seen_nxt = '0;
      end
    end
  end

  // Frame FSM with registered word/valid/overrun outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SYNC;
      seen        <= '0;
      shadow_word <= '0;
      shadow_bad  <= '0;
      word_out    <= '0;
      bad_out     <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      shadow_word <= shadow_word_nxt;
      shadow_bad  <= shadow_bad_nxt;
      seen        <= seen_nxt;
      if (take) state <= COLLECT;
      if (complete) begin
        if (!out_valid || out_ready) begin
          word_out  <= shadow_word_nxt;
          bad_out   <= shadow_bad_nxt;
          out_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: directed scenarios plus random bus traffic, every
// cycle compared against a frame-level reference model.
module tb_ssd_capture;
  localparam int D = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [6:0]     seg = 7'h7F;
  logic [D-1:0]   an = '1;
  logic           rdy = 1'b0;
  logic [4*D-1:0] word_out;
  logic [D-1:0]   bad_out;
  logic           out_valid, overrun;

  ssd_capture #(.DIGITS(D), .STABLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg), .an_in(an),
    .word_out(word_out), .bad_out(bad_out), .out_valid(out_valid),
    .out_ready(rdy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Segment code for each nibble value.
  logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- reference model ----------------
  logic [D+6:0]   m_prev;
  int             m_run;
  bit             m_pend;
  int             m_pidx;
  logic [6:0]     m_pseg;
  bit             m_collect;
  bit             m_seen [D];
  logic [3:0]     m_nib [D];
  bit             m_bd [D];
  logic [4*D-1:0] m_word;
  logic [D-1:0]   m_badv;
  bit             m_valid, m_ovr;

  task automatic model_edge();
    bit done, all, found;
    if (!rst_n) begin
      m_prev = {{D{1'b1}}, 7'h7F}; m_run = 0; m_pend = 0; m_collect = 0;
      for (int i = 0; i < D; i++) begin m_seen[i] = 0; m_nib[i] = 0; m_bd[i] = 0; end
      m_word = '0; m_badv = '0; m_valid = 0; m_ovr = 0;
      return;
    end
    done = 0;
    if (m_pend && (m_collect || m_pidx == 0)) begin
      if (!m_collect) for (int i = 0; i < D; i++) m_seen[i] = 0;
      m_collect = 1;
      found = 0;
      m_nib[m_pidx] = 4'h0;
      for (int v = 0; v < 16; v++)
        if (tab[v] == m_pseg) begin m_nib[m_pidx] = 4'(v); found = 1; end
      m_bd[m_pidx] = !found;
      m_seen[m_pidx] = 1;
      all = 1;
      for (int i = 0; i < D; i++) if (!m_seen[i]) all = 0;
      if (all) begin
        done = 1;
        for (int i = 0; i < D; i++) m_seen[i] = 0;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        for (int i = 0; i < D; i++) begin m_word[4*i +: 4] = m_nib[i]; m_badv[i] = m_bd[i]; end
        m_valid = 1;
      end else m_ovr = 1;
    end else if (m_valid && rdy) m_valid = 0;
    // settle detection: capture when a pattern has been seen exactly S times in a row
    if ({an, seg} == m_prev) m_run++; else m_run = 1;
    m_prev = {an, seg};
    m_pend = (m_run == S) && ($countones(~an) == 1);
    for (int i = 0; i < D; i++) if (!an[i]) m_pidx = i;
    m_pseg = seg;
  endtask

  // ---------------- stimulus helpers ----------------
  int             pulses = 0;
  logic [4*D-1:0] first_word;
  logic [D-1:0]   first_bad;
  bit             prev_v = 0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out", {42'd0, out_valid, overrun, bad_out, word_out},
               {42'd0, m_valid, m_ovr, m_badv, m_word});
    if (out_valid && !prev_v) begin
      pulses++;
      if (pulses == 1) begin first_word = word_out; first_bad = bad_out; end
    end
    prev_v = out_valid;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    an  = (d < 0) ? '1 : ~(D'(1) << d);
    seg = s;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(); step();
    chk("reset", {42'd0, out_valid, overrun, bad_out, word_out}, 64'd0);
    rst_n = 1;
    pulses = 0;
  endtask

  task automatic scan(input logic [6:0] s0, s1, s2, s3);
    show(0, s0, 6); show(1, s1, 6); show(2, s2, 6); show(3, s3, 6);
  endtask

  initial begin
    // basic frame
    do_reset(); rdy = 1;
    scan(7'h40, 7'h79, 7'h24, 7'h30);
    show(-1, 7'h7F, 8);
    chk("s1_pulses", pulses, 1);
    chk("s1_word", first_word, 16'h3210);
    chk("s1_bad", first_bad, 0);
    chk("s1_ovr", overrun, 0);

    // alignment: digits 2,3 before digit 0 are ignored
    do_reset(); rdy = 1;
    show(2, 7'h78, 6); show(3, 7'h03, 6);
    scan(7'h12, 7'h02, 7'h78, 7'h03);
    scan(7'h12, 7'h02, 7'h78, 7'h03);
    show(-1, 7'h7F, 8);
    chk("s2_word", first_word, 16'hB765);
    chk("s2_pulses", pulses, 2);

    // glitch rejection
    do_reset(); rdy = 1;
    show(0, 7'h40, 6);
    repeat (4) begin show(1, 7'h79, 2); show(1, 7'h24, 2); end
    show(1, 7'h24, 6); show(2, 7'h24, 6); show(3, 7'h30, 6);
    show(-1, 7'h7F, 10);
    chk("s3_word", first_word, 16'h3220);
    chk("s3_pulses", pulses, 1);

    // backpressure
    do_reset(); rdy = 0;
    scan(7'h40, 7'h79, 7'h24, 7'h30);
    scan(7'h12, 7'h02, 7'h78, 7'h03);
    show(-1, 7'h7F, 4);
    chk("s4_held", word_out, 16'h3210);
    chk("s4_valid", out_valid, 1);
    chk("s4_ovr", overrun, 1);
    rdy = 1; step();
    chk("s4_drop", out_valid, 0);
    show(-1, 7'h7F, 5);
    chk("s4_sticky", overrun, 1);

    // unrecognised pattern
    do_reset(); rdy = 1;
    scan(7'h40, 7'h40, 7'h40, 7'h7F);
    show(-1, 7'h7F, 8);
    chk("s5_word", first_word, 16'h0000);
    chk("s5_bad", first_bad, 4'b1000);

    // reset mid-frame
    do_reset(); rdy = 1;
    show(0, 7'h40, 6); show(1, 7'h79, 6);
    do_reset();
    scan(7'h0E, 7'h06, 7'h21, 7'h46);
    show(-1, 7'h7F, 8);
    chk("s6_word", first_word, 16'hCDEF);
    chk("s6_pulses", pulses, 1);

    // random traffic
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int d;
      d = int'($urandom_range(0, 5));
      if (d < D) an = ~(D'(1) << d);
      else if (d == D) an = '1;
      else an = D'($urandom);
      seg = ($urandom_range(0, 3) != 0) ? tab[$urandom_range(0, 15)] : 7'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0; step(); rst_n = 1;
      end
      repeat ($urandom_range(1, 7)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
